// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: per-entry record and default widths.
package rob_types;

  localparam int ROB_TAG_W = 6;
  localparam int PREG_W    = 6;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              mispredict;
    logic              is_branch;
    logic              rd_used;
    logic [PREG_W-1:0] rd_new_p;
    logic [PREG_W-1:0] rd_old_p;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of dispatch, writeback and commit signals between rename, execute and the ROB.
// Dispatch transfers on a rising edge where disp_valid_i && disp_ready_o; valid never waits on ready.
interface reorder_buffer_if #(
  parameter int ROB_TAG_W = 6,
  parameter int N_PHYS    = 64
);
  localparam int PREG_W = $clog2(N_PHYS);

  logic                 disp_valid_i;
  logic                 disp_ready_o;
  logic [ROB_TAG_W-1:0] disp_tag_i;
  logic                 disp_rd_used_i;
  logic [PREG_W-1:0]    disp_rd_new_p_i;
  logic [PREG_W-1:0]    disp_rd_old_p_i;
  logic                 disp_is_branch_i;
  logic                 wb_valid_i;
  logic [ROB_TAG_W-1:0] wb_tag_i;
  logic                 wb_mispredict_i;
  logic                 commit_valid_o;
  logic [ROB_TAG_W-1:0] commit_tag_o;
  logic [PREG_W-1:0]    commit_rd_new_p_o;
  logic                 commit_free_valid_o;
  logic [PREG_W-1:0]    commit_free_preg_o;
  logic                 recover_o;
  logic [ROB_TAG_W:0]   count_o;
  logic                 empty_o;

  modport master (
    output disp_valid_i, disp_tag_i, disp_rd_used_i, disp_rd_new_p_i, disp_rd_old_p_i,
           disp_is_branch_i, wb_valid_i, wb_tag_i, wb_mispredict_i,
    input  disp_ready_o, commit_valid_o, commit_tag_o, commit_rd_new_p_o,
           commit_free_valid_o, commit_free_preg_o, recover_o, count_o, empty_o
  );

  modport slave (
    input  disp_valid_i, disp_tag_i, disp_rd_used_i, disp_rd_new_p_i, disp_rd_old_p_i,
           disp_is_branch_i, wb_valid_i, wb_tag_i, wb_mispredict_i,
    output disp_ready_o, commit_valid_o, commit_tag_o, commit_rd_new_p_o,
           commit_free_valid_o, commit_free_preg_o, recover_o, count_o, empty_o
  );

endinterface

// File: rtl/reorder_buffer_perf.sv
// Free-running retire and flush event counters; both wrap on overflow.
module reorder_buffer_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire_i,
  input  logic        flush_i,
  output logic [31:0] commit_cnt_o,
  output logic [31:0] flush_cnt_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_cnt_o <= '0;
      flush_cnt_o  <= '0;
    end else begin
      if (retire_i) commit_cnt_o <= commit_cnt_o + 32'd1;
      if (flush_i)  flush_cnt_o  <= flush_cnt_o + 32'd1;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: retires one done entry per cycle, squashes on a mispredicted head branch.
// Optional ROB_PERF_CNT_EN adds retire/flush event counter outputs.
module reorder_buffer
  import rob_types::rob_entry_t;
#(
  parameter int ROB_TAG_W = rob_types::ROB_TAG_W,
  parameter int N_PHYS    = 64
) (
  input  logic        clk,
  input  logic        rst,
  reorder_buffer_if.slave rob
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0] perf_commit_cnt_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);

  localparam int DEPTH  = 2 ** ROB_TAG_W;
  localparam int PREG_W = $clog2(N_PHYS);
  // Entry storage width comes from the package; N_PHYS must not exceed 2**rob_types::PREG_W.
  localparam int SW     = rob_types::PREG_W;

  rob_entry_t           ent [DEPTH];
  rob_entry_t           head_e;
  rob_entry_t           new_e;
  logic [ROB_TAG_W-1:0] head;
  logic [ROB_TAG_W-1:0] tail;
  logic [ROB_TAG_W:0]   count;
  logic                 head_rdy;
  logic                 flush_now;
  logic                 retire_now;
  logic                 disp_fire;
  logic                 recover_q;
  logic                 commit_valid_q;
  logic [ROB_TAG_W-1:0] commit_tag_q;
  logic [PREG_W-1:0]    commit_new_q;
  logic                 free_valid_q;
  logic [PREG_W-1:0]    free_preg_q;

  always_comb begin
    head_e     = ent[head];
    head_rdy   = head_e.valid && head_e.done;
    flush_now  = head_rdy && head_e.mispredict;
    retire_now = head_rdy && !flush_now;

    new_e           = '0;
    new_e.valid     = 1'b1;
    new_e.is_branch = rob.disp_is_branch_i;
    new_e.rd_used   = rob.disp_rd_used_i;
    new_e.rd_new_p  = SW'(rob.disp_rd_new_p_i);
    new_e.rd_old_p  = SW'(rob.disp_rd_old_p_i);
  end

  assign rob.disp_ready_o = (count < (ROB_TAG_W+1)'(DEPTH)) && !flush_now && !recover_q;
  assign disp_fire        = rob.disp_valid_i && rob.disp_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      recover_q      <= 1'b0;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_new_q   <= '0;
      free_valid_q   <= 1'b0;
      free_preg_q    <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
    end else begin
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_new_q   <= '0;
      free_valid_q   <= 1'b0;
      free_preg_q    <= '0;
      recover_q      <= 1'b0;

      // done is only read from registers, so a head writeback is seen by commit a cycle later
      if (rob.wb_valid_i && ent[rob.wb_tag_i].valid) begin
        ent[rob.wb_tag_i].done       <= 1'b1;
        ent[rob.wb_tag_i].mispredict <= rob.wb_mispredict_i && ent[rob.wb_tag_i].is_branch;
      end

      if (retire_now) begin
        ent[head].valid <= 1'b0;
        head            <= head + 1'b1;
        commit_valid_q  <= 1'b1;
        commit_tag_q    <= head;
        commit_new_q    <= PREG_W'(head_e.rd_new_p);
        free_valid_q    <= head_e.rd_used;
        free_preg_q     <= PREG_W'(head_e.rd_old_p);
      end

      if (disp_fire) begin
        ent[tail] <= new_e;
        tail      <= tail + 1'b1;
      end

      count <= count + (ROB_TAG_W+1)'(disp_fire) - (ROB_TAG_W+1)'(retire_now);

      // Rename rewinds to the branch's own checkpoint, so its tag is handed out again
      if (flush_now) begin
        for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
        tail      <= head;
        count     <= '0;
        recover_q <= 1'b1;
      end
    end
  end

  assign rob.commit_valid_o      = commit_valid_q;
  assign rob.commit_tag_o        = commit_tag_q;
  assign rob.commit_rd_new_p_o   = commit_new_q;
  assign rob.commit_free_valid_o = free_valid_q;
  assign rob.commit_free_preg_o  = free_preg_q;
  assign rob.recover_o           = recover_q;
  assign rob.count_o             = count;
  assign rob.empty_o             = (count == '0);

  tag_matches_tail: assert property (@(posedge clk) disable iff (rst)
    disp_fire |-> (rob.disp_tag_i == tail))
    else $error("reorder_buffer: dispatch tag differs from tail pointer");

`ifdef ROB_PERF_CNT_EN
  reorder_buffer_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .retire_i     (retire_now),
    .flush_i      (flush_now),
    .commit_cnt_o (perf_commit_cnt_o),
    .flush_cnt_o  (perf_flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic against a program-order queue model.
module tb_reorder_buffer;

  localparam int TW = 6;
  localparam int NP = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reorder_buffer_if #(.ROB_TAG_W(TW), .N_PHYS(NP)) bus ();

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_commit_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  reorder_buffer #(.ROB_TAG_W(TW), .N_PHYS(NP)) dut (
    .clk (clk),
    .rst (rst),
    .rob (bus)
`ifdef ROB_PERF_CNT_EN
    ,
    .perf_commit_cnt_o (perf_commit_cnt),
    .perf_flush_cnt_o  (perf_flush_cnt)
`endif
  );

  // commit record: {tag[18:13], new_p[12:7], free_valid[6], free_preg[5:0]}
  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];
  int          obs_cyc[$];
  int          exp_rec = 0;
  int          obs_rec = 0;
  int          rec_long = 0;
  int          rec_ready_bad = 0;
  int          idle_bad = 0;
  logic        prev_rec = 1'b0;
  logic        prev_ready = 1'b0;

  always @(negedge clk) begin
    if (bus.commit_valid_o) begin
      obs_q.push_back({bus.commit_tag_o, bus.commit_rd_new_p_o,
                       bus.commit_free_valid_o, bus.commit_free_preg_o});
      obs_cyc.push_back(cyc);
    end else if (bus.commit_free_valid_o || bus.commit_tag_o != 0 ||
                 bus.commit_rd_new_p_o != 0 || bus.commit_free_preg_o != 0) begin
      idle_bad++;
    end
    if (bus.recover_o) begin
      obs_rec++;
      if (prev_rec) rec_long++;
      if (bus.disp_ready_o || prev_ready) rec_ready_bad++;
    end
    prev_rec   = bus.recover_o;
    prev_ready = bus.disp_ready_o;
  end

  // program-order model of in-flight instructions
  typedef struct {
    logic [5:0] tag;
    bit         used;
    logic [5:0] np;
    logic [5:0] op;
    bit         br;
    bit         done;
    bit         mis;
  } inst_t;

  inst_t      infl[$];
  logic [5:0] m_tail = 6'd0;

  function automatic void model_drain();
    while (infl.size() > 0 && infl[0].done) begin
      if (infl[0].mis) begin
        m_tail = infl[0].tag;
        infl.delete();
        exp_rec++;
      end else begin
        exp_q.push_back({infl[0].tag, infl[0].np, infl[0].used, infl[0].op});
        void'(infl.pop_front());
      end
    end
  endfunction

  function automatic void clear_sb();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
    exp_rec = 0;
    obs_rec = 0;
    rec_long = 0;
    rec_ready_bad = 0;
    idle_bad = 0;
  endfunction

  task automatic idle_inputs();
    bus.disp_valid_i     = 1'b0;
    bus.disp_tag_i       = '0;
    bus.disp_rd_used_i   = 1'b0;
    bus.disp_rd_new_p_i  = '0;
    bus.disp_rd_old_p_i  = '0;
    bus.disp_is_branch_i = 1'b0;
    bus.wb_valid_i       = 1'b0;
    bus.wb_tag_i         = '0;
    bus.wb_mispredict_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    infl.delete();
    m_tail = 6'd0;
  endtask

  // One cycle of stimulus: optional dispatch (waits for ready) and optional writeback.
  task automatic cycle_op(input bit dv, input bit used, input int np, input int op, input bit br,
                          input bit wv, input int wt, input bit wm);
    int b;
    b = 0;
    while (obs_rec < exp_rec && b < 50) begin @(posedge clk); #1; b++; end
    if (dv) while (!bus.disp_ready_o && b < 200) begin @(posedge clk); #1; b++; end
    if (b >= 200) begin
      total++; bad++;
      $display("FAIL disp_ready_wait got=timeout exp=ready within 200 cycles");
    end
    bus.disp_valid_i     = dv;
    bus.disp_tag_i       = m_tail;
    bus.disp_rd_used_i   = used;
    bus.disp_rd_new_p_i  = 6'(np);
    bus.disp_rd_old_p_i  = 6'(op);
    bus.disp_is_branch_i = br;
    bus.wb_valid_i       = wv;
    bus.wb_tag_i         = 6'(wt);
    bus.wb_mispredict_i  = wm;
    @(posedge clk);
    #1;
    idle_inputs();
    if (wv) begin
      for (int i = 0; i < infl.size(); i++)
        if (infl[i].tag == 6'(wt) && !infl[i].done) begin
          infl[i].done = 1'b1;
          infl[i].mis  = wm && infl[i].br;
        end
    end
    if (dv) begin
      infl.push_back('{tag: m_tail, used: used, np: 6'(np), op: 6'(op), br: br, done: 1'b0, mis: 1'b0});
      m_tail = m_tail + 6'd1;
    end
    model_drain();
  endtask

  task automatic wait_drain(output bit ok);
    int b;
    b = 0;
    while ((obs_q.size() < exp_q.size() || obs_rec < exp_rec) && b < 300) begin
      @(posedge clk); #1; b++;
    end
    repeat (3) @(posedge clk);
    #1;
    ok = (b < 300);
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.commit_valid_o !== 1'b0) begin bad++; $display("FAIL rst_commit_valid got=%0b exp=0", bus.commit_valid_o); end
    total++; if (bus.commit_free_valid_o !== 1'b0) begin bad++; $display("FAIL rst_free_valid got=%0b exp=0", bus.commit_free_valid_o); end
    total++; if (bus.recover_o !== 1'b0) begin bad++; $display("FAIL rst_recover got=%0b exp=0", bus.recover_o); end
    total++; if (bus.count_o !== 7'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0b exp=1", bus.empty_o); end
    rst = 1'b0;
    infl.delete();
    m_tail = 6'd0;
    clear_sb();
    total++; if (bus.disp_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", bus.disp_ready_o); end
    for (int i = 0; i < 3; i++) cycle_op(1, 1, 20 + i, 5 + i, 0, 0, 0, 0);
    total++; if (bus.count_o !== 7'd3) begin bad++; $display("FAIL inorder_count got=%0d exp=3", bus.count_o); end
    for (int i = 2; i >= 0; i--) cycle_op(0, 0, 0, 0, 0, 1, i, 0);
    wait_drain(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL inorder_drain got=timeout exp=3 commits"); end
    total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL inorder_n got=%0d exp=3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== {6'(i), 6'(20 + i), 1'b1, 6'(5 + i)}) begin
        bad++; $display("FAIL inorder_rec%0d got=%h exp=%h", i, obs_q[i], {6'(i), 6'(20 + i), 1'b1, 6'(5 + i)});
      end
    end
    if (obs_cyc.size() == 3) begin
      total++;
      if (obs_cyc[2] - obs_cyc[0] !== 2) begin bad++; $display("FAIL inorder_b2b got=%0d exp=2 cycles", obs_cyc[2] - obs_cyc[0]); end
    end
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL inorder_empty got=%0b exp=1", bus.empty_o); end
  endtask

  task automatic test_fill();
    bit ok;
    do_reset();
    clear_sb();
    for (int i = 0; i < 64; i++) cycle_op(1, 1, i, 63 - i, 0, 0, 0, 0);
    total++; if (bus.count_o !== 7'd64) begin bad++; $display("FAIL fill_count got=%0d exp=64", bus.count_o); end
    total++; if (bus.disp_ready_o !== 1'b0) begin bad++; $display("FAIL fill_ready got=%0b exp=0", bus.disp_ready_o); end
    cycle_op(0, 0, 0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    total++; if (bus.disp_ready_o !== 1'b1) begin bad++; $display("FAIL fill_ready_after got=%0b exp=1", bus.disp_ready_o); end
    total++; if (bus.count_o !== 7'd63) begin bad++; $display("FAIL fill_count_after got=%0d exp=63", bus.count_o); end
    wait_drain(ok);
    total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL fill_n got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL fill_rec%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int t;
    do_reset();
    clear_sb();
    for (int i = 0; i < 100; i++) begin
      t = int'(m_tail);
      cycle_op(1, 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 63), 0, 0, 0, 0);
      cycle_op(0, 0, 0, 0, 0, 1, t, 0);
    end
    wait_drain(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL wrap_drain got=timeout exp=100 commits"); end
    total++; if (obs_q.size() !== 100) begin bad++; $display("FAIL wrap_n got=%0d exp=100", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_rec%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    if (obs_q.size() > 64) begin
      total++; if (obs_q[63][18:13] !== 6'd63) begin bad++; $display("FAIL wrap_tag63 got=%0d exp=63", obs_q[63][18:13]); end
      total++; if (obs_q[64][18:13] !== 6'd0) begin bad++; $display("FAIL wrap_tag64 got=%0d exp=0", obs_q[64][18:13]); end
    end
  endtask

  task automatic test_mispredict();
    bit ok;
    do_reset();
    clear_sb();
    for (int i = 0; i < 6; i++) cycle_op(1, 1, 40 + i, 20 + i, (i == 3), 0, 0, 0);
    cycle_op(0, 0, 0, 0, 0, 1, 4, 0);
    cycle_op(0, 0, 0, 0, 0, 1, 3, 1);
    for (int i = 0; i < 3; i++) cycle_op(0, 0, 0, 0, 0, 1, i, 0);
    wait_drain(ok);
    total++; if (obs_rec !== 1) begin bad++; $display("FAIL mis_recover_n got=%0d exp=1", obs_rec); end
    total++; if (rec_long !== 0) begin bad++; $display("FAIL mis_recover_len got=%0d exp=0 long pulses", rec_long); end
    total++; if (rec_ready_bad !== 0) begin bad++; $display("FAIL mis_ready_low got=%0d exp=0", rec_ready_bad); end
    total++; if (bus.count_o !== 7'd0) begin bad++; $display("FAIL mis_count got=%0d exp=0", bus.count_o); end
    total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL mis_n got=%0d exp=3", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL mis_rec%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    cycle_op(1, 1, 50, 51, 0, 0, 0, 0);
    cycle_op(0, 0, 0, 0, 0, 1, 3, 0);
    wait_drain(ok);
    total++; if (obs_q.size() !== 4) begin bad++; $display("FAIL mis_reuse_n got=%0d exp=4", obs_q.size()); end
    if (obs_q.size() == 4) begin
      total++; if (obs_q[3] !== {6'd3, 6'd50, 1'b1, 6'd51}) begin bad++; $display("FAIL mis_reuse_tag got=%h exp=%h", obs_q[3], {6'd3, 6'd50, 1'b1, 6'd51}); end
    end
  endtask

  task automatic test_early_wb();
    bit ok;
    do_reset();
    clear_sb();
    cycle_op(1, 0, 11, 9, 0, 0, 0, 0);
    cycle_op(1, 1, 13, 12, 0, 0, 0, 0);
    cycle_op(0, 0, 0, 0, 0, 1, 1, 0);
    repeat (4) @(posedge clk);
    #1;
    total++; if (obs_q.size() !== 0) begin bad++; $display("FAIL early_nocommit got=%0d exp=0", obs_q.size()); end
    cycle_op(0, 0, 0, 0, 0, 1, 0, 0);
    wait_drain(ok);
    total++; if (obs_q.size() !== 2) begin bad++; $display("FAIL early_n got=%0d exp=2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      total++; if (obs_q[0] !== {6'd0, 6'd11, 1'b0, 6'd9}) begin bad++; $display("FAIL early_nofree got=%h exp=%h", obs_q[0], {6'd0, 6'd11, 1'b0, 6'd9}); end
      total++; if (obs_q[1] !== {6'd1, 6'd13, 1'b1, 6'd12}) begin bad++; $display("FAIL early_second got=%h exp=%h", obs_q[1], {6'd1, 6'd13, 1'b1, 6'd12}); end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    do_reset();
    clear_sb();
    for (int i = 0; i < 10; i++) cycle_op(1, 1, i, i + 30, (i == 5), 0, 0, 0);
    cycle_op(0, 0, 0, 0, 0, 1, 4, 0);
    cycle_op(0, 0, 0, 0, 0, 1, 5, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    infl.delete();
    m_tail = 6'd0;
    total++; if (bus.count_o !== 7'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", bus.count_o); end
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL midrst_empty got=%0b exp=1", bus.empty_o); end
    repeat (4) @(posedge clk);
    #1;
    total++; if (obs_q.size() !== 0 || obs_rec !== 0) begin bad++; $display("FAIL midrst_pulses got=%0d commits %0d recovers exp=0", obs_q.size(), obs_rec); end
    cycle_op(1, 1, 7, 8, 0, 0, 0, 0);
    cycle_op(0, 0, 0, 0, 0, 1, 0, 0);
    wait_drain(ok);
    total++; if (obs_q.size() !== 1) begin bad++; $display("FAIL midrst_after_n got=%0d exp=1", obs_q.size()); end
    if (obs_q.size() == 1) begin
      total++; if (obs_q[0] !== {6'd0, 6'd7, 1'b1, 6'd8}) begin bad++; $display("FAIL midrst_after got=%h exp=%h", obs_q[0], {6'd0, 6'd7, 1'b1, 6'd8}); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int pend[$];
    bit dv, wv;
    int wt;
    do_reset();
    clear_sb();
    for (int n = 0; n < 400; n++) begin
      pend.delete();
      for (int i = 0; i < infl.size(); i++) if (!infl[i].done) pend.push_back(int'(infl[i].tag));
      dv = (infl.size() < 64) && ($urandom_range(0, 3) != 0);
      wv = (pend.size() > 0) && ($urandom_range(0, 2) != 0);
      wt = wv ? pend[$urandom_range(0, pend.size() - 1)] : 0;
      cycle_op(dv, 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 63),
               ($urandom_range(0, 3) == 0), wv, wt, ($urandom_range(0, 4) == 0));
    end
    for (int n = 0; n < 200 && infl.size() > 0; n++) begin
      wt = -1;
      for (int i = 0; i < infl.size(); i++) if (!infl[i].done && wt < 0) wt = int'(infl[i].tag);
      if (wt >= 0) cycle_op(0, 0, 0, 0, 0, 1, wt, 0);
    end
    wait_drain(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rand_drain got=timeout exp=%0d commits", exp_q.size()); end
    total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_n got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_rec%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (obs_rec !== exp_rec) begin bad++; $display("FAIL rand_recover_n got=%0d exp=%0d", obs_rec, exp_rec); end
    total++; if (rec_long !== 0 || rec_ready_bad !== 0) begin bad++; $display("FAIL rand_recover_shape got=%0d/%0d exp=0/0", rec_long, rec_ready_bad); end
    total++; if (idle_bad !== 0) begin bad++; $display("FAIL rand_idle_outputs got=%0d exp=0", idle_bad); end
    total++; if (bus.empty_o !== 1'b1) begin bad++; $display("FAIL rand_empty got=%0b exp=1", bus.empty_o); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill();
    test_wrap();
    test_mispredict();
    test_early_wb();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
